switch_post: RTL

Egress serializer of the switch core. It pops one frame descriptor from the output pointer FIFO and reads that frame's 128-bit cells from the output cell data FIFO. It emits the frame MSB-byte-first as a byte stream with `sof`/`dv` toward the port MAC. It is the exact inverse of the ingress cell packer and uses the same cell and pointer formats.

---
 rtl/switch_post.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/switch_post.sv
// rtl/switch_post.sv - egress serializer: pointer/cell FIFOs to MSB-first byte stream
module switch_post #(
    parameter int IFG = 12
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic [15:0]  o_cell_ptr_fifo_din,
    input  logic         o_cell_ptr_fifo_empty,
    output logic         o_cell_ptr_fifo_rd,
    input  logic [127:0] o_cell_data_fifo_din,
    input  logic         o_cell_data_fifo_empty,
    output logic         o_cell_data_fifo_rd,
    input  logic         tx_pause,
    output logic         sof,
    output logic         dv,
    output logic [7:0]   dout,
    output logic [3:0]   portmap,
    output logic         drop,
    output logic         underrun
);

    typedef enum logic [2:0] {
        IDLE,
        PTR_WAIT,
        PTR_LAT,
        CELL_WAIT,
        SEND,
        STALL,
        GAP
    } state_t;

    state_t        state, state_n;
    logic          wait_done, wait_n;
    logic [127:0]  shreg, shreg_n;
    logic [3:0]    byte_idx, byte_n;
    logic [7:0]    cells_left, cells_n;
    logic [7:0]    gap_cnt, gap_n;
    logic          first_cell, first_n;
    logic          stall_pend, stall_n;
    logic          ptr_rd_n, data_rd_n, sof_n, dv_n, drop_n, underrun_n;
    logic [7:0]    dout_n;
    logic [3:0]    portmap_n;

    // Descriptor bits outside portmap/N, and the byte already on dout, are never consumed
    logic unused_bits;
    assign unused_bits = ^{o_cell_ptr_fifo_din[15:12], o_cell_ptr_fifo_din[7:6], shreg[127:120]};

    // State and every output register; reset aborts a frame in flight
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state               <= IDLE;
            wait_done           <= 1'b0;
            shreg               <= '0;
            byte_idx            <= '0;
            cells_left          <= '0;
            gap_cnt             <= '0;
            first_cell          <= 1'b0;
            stall_pend          <= 1'b0;
            o_cell_ptr_fifo_rd  <= 1'b0;
            o_cell_data_fifo_rd <= 1'b0;
            sof                 <= 1'b0;
            dv                  <= 1'b0;
            dout                <= '0;
            portmap             <= '0;
            drop                <= 1'b0;
            underrun            <= 1'b0;
        end else begin
            state               <= state_n;
            wait_done           <= wait_n;
            shreg               <= shreg_n;
            byte_idx            <= byte_n;
            cells_left          <= cells_n;
            gap_cnt             <= gap_n;
            first_cell          <= first_n;
            stall_pend          <= stall_n;
            o_cell_ptr_fifo_rd  <= ptr_rd_n;
            o_cell_data_fifo_rd <= data_rd_n;
            sof                 <= sof_n;
            dv                  <= dv_n;
            dout                <= dout_n;
            portmap             <= portmap_n;
            drop                <= drop_n;
            underrun            <= underrun_n;
        end
    end

    // Next-state and next-output decode; pulses default low, held values default to current
    always_comb begin
        state_n    = state;
        wait_n     = wait_done;
        shreg_n    = shreg;
        byte_n     = byte_idx;
        cells_n    = cells_left;
        gap_n      = gap_cnt;
        first_n    = first_cell;
        stall_n    = stall_pend;
        ptr_rd_n   = 1'b0;
        data_rd_n  = 1'b0;
        sof_n      = 1'b0;
        dv_n       = 1'b0;
        dout_n     = 8'h00;
        portmap_n  = portmap;
        drop_n     = 1'b0;
        underrun_n = underrun;

        case (state)
            IDLE: begin
                if (!o_cell_ptr_fifo_empty && !tx_pause) begin
                    ptr_rd_n = 1'b1;
                    state_n  = PTR_WAIT;
                end
            end

            PTR_WAIT: state_n = PTR_LAT;

            PTR_LAT: begin
                portmap_n = o_cell_ptr_fifo_din[11:8];
                cells_n   = {o_cell_ptr_fifo_din[5:0], 2'b00};
                first_n   = 1'b1;
                stall_n   = 1'b0;
                if (o_cell_ptr_fifo_din[5:0] == 6'd0) begin
                    drop_n  = 1'b1;
                    state_n = IDLE;
                end else if (o_cell_data_fifo_empty) begin
                    underrun_n = 1'b1;
                    state_n    = STALL;
                end else begin
                    data_rd_n = 1'b1;
                    wait_n    = 1'b0;
                    state_n   = CELL_WAIT;
                end
            end

            // First cycle lets the FIFO take the pop, second loads the returned cell
            CELL_WAIT: begin
                if (!wait_done) begin
                    wait_n = 1'b1;
                end else begin
                    shreg_n = o_cell_data_fifo_din;
                    dout_n  = o_cell_data_fifo_din[127:120];
                    dv_n    = 1'b1;
                    sof_n   = first_cell;
                    first_n = 1'b0;
                    byte_n  = 4'd0;
                    state_n = SEND;
                end
            end

            SEND: begin
                // Prefetch the next cell so it lands exactly when byte 15 ends
                if (byte_idx == 4'd13 && cells_left > 8'd1) begin
                    if (o_cell_data_fifo_empty) begin
                        underrun_n = 1'b1;
                        stall_n    = 1'b1;
                    end else begin
                        data_rd_n = 1'b1;
                    end
                end
                if (byte_idx != 4'd15) begin
                    shreg_n = {shreg[119:0], 8'h00};
                    dout_n  = shreg[119:112];
                    dv_n    = 1'b1;
                    byte_n  = byte_idx + 4'd1;
                end else if (cells_left > 8'd1) begin
                    cells_n = cells_left - 8'd1;
                    byte_n  = 4'd0;
                    if (stall_pend) begin
                        stall_n = 1'b0;
                        state_n = STALL;
                    end else begin
                        shreg_n = o_cell_data_fifo_din;
                        dout_n  = o_cell_data_fifo_din[127:120];
                        dv_n    = 1'b1;
                    end
                end else begin
                    gap_n   = 8'(IFG - 1);
                    state_n = GAP;
                end
            end

            STALL: begin
                if (!o_cell_data_fifo_empty) begin
                    data_rd_n = 1'b1;
                    wait_n    = 1'b0;
                    state_n   = CELL_WAIT;
                end
            end

            GAP: begin
                if (gap_cnt == 8'd0) begin
                    state_n = IDLE;
                end else begin
                    gap_n = gap_cnt - 8'd1;
                end
            end

            default: state_n = IDLE;
        endcase
    end

endmodule
